// File: rtl/eth_tx_arb_if.sv
// Stream bundle between the two requesters, the arbiter and the MAC TX port.
// The arbiter connects through the slave modport; the requester/MAC side
// (or a bench) uses the master modport.
interface eth_tx_arb_if #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int TAG_WIDTH  = 16
);
  // Requester side, port p lives at [p*WIDTH +: WIDTH]
  logic [2*DATA_WIDTH-1:0] s_axis_tdata;
  logic [2*KEEP_WIDTH-1:0] s_axis_tkeep;
  logic [1:0]              s_axis_tlast;
  logic [1:0]              s_axis_tvalid;
  logic [1:0]              s_axis_tready;

  // MAC TX side
  logic [DATA_WIDTH-1:0]   tx_axis_tdata;
  logic [KEEP_WIDTH-1:0]   tx_axis_tkeep;
  logic                    tx_axis_tlast;
  logic                    tx_axis_tvalid;
  logic                    tx_axis_tready;
  logic [TAG_WIDTH:0]      tx_axis_tuser;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, tx_axis_tready,
    output s_axis_tready, tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast, tx_axis_tvalid,
           tx_axis_tuser
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, tx_axis_tready,
    input  s_axis_tready, tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast, tx_axis_tvalid,
           tx_axis_tuser
  );
endinterface

// File: rtl/eth_tx_arb.sv
// Two-port round-robin frame arbiter in front of a MAC TX stream.
// Each frame is tagged with {port, per-port sequence number} in tuser so the
// MAC's returned PTP timestamp can be routed back to the requester that owns
// it. Timestamps whose tag names a frame not yet sent are dropped and counted.
module eth_tx_arb #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int TAG_WIDTH  = 16
) (
  input  logic                 tx_clk,
  input  logic                 tx_rst_n,
  eth_tx_arb_if.slave          bus,
  input  logic [95:0]          tx_ptp_ts,
  input  logic [TAG_WIDTH-1:0] tx_ptp_ts_tag,
  input  logic                 tx_ptp_ts_valid,
  output logic [95:0]          m_ptp_ts,
  output logic [1:0]           m_ptp_ts_valid,
  output logic [15:0]          drop_count
);

  localparam int SEQ_W = TAG_WIDTH - 1;
  localparam logic [SEQ_W-1:0] SEQ_ONE = {{(SEQ_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_rr_ptr;
  logic   r_grant_port;
  logic   w_grant_nxt;

  logic [SEQ_W-1:0] r_seq0;
  logic [SEQ_W-1:0] r_seq1;
  logic [SEQ_W-1:0] w_seq_cur;

  logic [DATA_WIDTH-1:0] w_tdata;
  logic [KEEP_WIDTH-1:0] w_tkeep;
  logic                  w_tlast;
  logic                  w_tvalid;
  logic [1:0]            w_s_tready;
  logic                  w_hs_last;

  logic [95:0]      r_ptp_ts;
  logic [1:0]       r_ptp_ts_valid;
  logic [15:0]      r_drop_count;
  logic             w_ts_port;
  logic [SEQ_W-1:0] w_ts_seq;
  logic [SEQ_W-1:0] w_ts_ref;
  logic             w_ts_drop;

  // Arbitration and frame-end detection: pick the next owner in IDLE, leave BUSY on the last beat
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_port;
    case (r_state)
      ST_IDLE: begin
        if (bus.s_axis_tvalid[r_rr_ptr]) begin
          w_grant_nxt = r_rr_ptr;
          w_state_nxt = ST_BUSY;
        end else if (bus.s_axis_tvalid[~r_rr_ptr]) begin
          w_grant_nxt = ~r_rr_ptr;
          w_state_nxt = ST_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (w_hs_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 1'b0;
      end
    endcase
  end

  // Datapath mux: in BUSY the granted port is wired straight through; IDLE presents nothing
  always_comb begin
    w_tdata    = {DATA_WIDTH{1'b0}};
    w_tkeep    = {KEEP_WIDTH{1'b0}};
    w_tlast    = 1'b0;
    w_tvalid   = 1'b0;
    w_s_tready = 2'b00;
    if (r_state == ST_BUSY) begin
      if (r_grant_port) begin
        w_tdata    = bus.s_axis_tdata[DATA_WIDTH +: DATA_WIDTH];
        w_tkeep    = bus.s_axis_tkeep[KEEP_WIDTH +: KEEP_WIDTH];
        w_tlast    = bus.s_axis_tlast[1];
        w_tvalid   = bus.s_axis_tvalid[1];
        w_s_tready = {bus.tx_axis_tready, 1'b0};
      end else begin
        w_tdata    = bus.s_axis_tdata[0 +: DATA_WIDTH];
        w_tkeep    = bus.s_axis_tkeep[0 +: KEEP_WIDTH];
        w_tlast    = bus.s_axis_tlast[0];
        w_tvalid   = bus.s_axis_tvalid[0];
        w_s_tready = {1'b0, bus.tx_axis_tready};
      end
    end else begin
      w_s_tready = 2'b00;
    end
  end

  assign w_hs_last = (r_state == ST_BUSY) & w_tvalid & bus.tx_axis_tready & w_tlast;
  assign w_seq_cur = r_grant_port ? r_seq1 : r_seq0;

  // Arbiter state: FSM register, grant capture, round-robin pointer and per-port frame counters
  always_ff @(posedge tx_clk) begin
    if (!tx_rst_n) begin
      r_state      <= ST_IDLE;
      r_grant_port <= 1'b0;
      r_rr_ptr     <= 1'b0;
      r_seq0       <= {SEQ_W{1'b0}};
      r_seq1       <= {SEQ_W{1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_grant_port <= w_grant_nxt;
      if (w_hs_last) begin
        r_rr_ptr <= ~r_grant_port;
        if (r_grant_port) begin
          r_seq1 <= r_seq1 + SEQ_ONE;
        end else begin
          r_seq0 <= r_seq0 + SEQ_ONE;
        end
      end else begin
        r_rr_ptr <= r_rr_ptr;
      end
    end
  end

  // A returned tag is stale-proofed against the owner's counter: a tag at or beyond it was never sent
  assign w_ts_port = tx_ptp_ts_tag[TAG_WIDTH-1];
  assign w_ts_seq  = tx_ptp_ts_tag[SEQ_W-1:0];
  assign w_ts_ref  = w_ts_port ? r_seq1 : r_seq0;
  assign w_ts_drop = (w_ts_seq >= w_ts_ref);

  // Timestamp return: route a one-cycle valid pulse to the owning port, or count a drop
  always_ff @(posedge tx_clk) begin
    if (!tx_rst_n) begin
      r_ptp_ts       <= 96'd0;
      r_ptp_ts_valid <= 2'b00;
      r_drop_count   <= 16'd0;
    end else begin
      r_ptp_ts_valid <= 2'b00;
      if (tx_ptp_ts_valid) begin
        r_ptp_ts <= tx_ptp_ts;
        if (w_ts_drop) begin
          if (r_drop_count != 16'hFFFF) begin
            r_drop_count <= r_drop_count + 16'd1;
          end else begin
            r_drop_count <= r_drop_count;
          end
        end else begin
          r_ptp_ts_valid <= w_ts_port ? 2'b10 : 2'b01;
        end
      end else begin
        r_ptp_ts <= r_ptp_ts;
      end
    end
  end

  assign bus.tx_axis_tdata  = w_tdata;
  assign bus.tx_axis_tkeep  = w_tkeep;
  assign bus.tx_axis_tlast  = w_tlast;
  assign bus.tx_axis_tvalid = w_tvalid;
  assign bus.tx_axis_tuser  = {r_grant_port, w_seq_cur, 1'b0};
  assign bus.s_axis_tready  = w_s_tready;

  assign m_ptp_ts       = r_ptp_ts;
  assign m_ptp_ts_valid = r_ptp_ts_valid;
  assign drop_count     = r_drop_count;

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed bench for eth_tx_arb: frame arbitration, tagging, timestamp routing,
// mid-frame reset and sequence wrap, all with hand-computed expectations.
module tb_eth_tx_arb;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int TW = 16;

  logic          tx_clk = 1'b0;
  logic          tx_rst_n;
  logic [95:0]   tx_ptp_ts;
  logic [TW-1:0] tx_ptp_ts_tag;
  logic          tx_ptp_ts_valid;
  logic [95:0]   m_ptp_ts;
  logic [1:0]    m_ptp_ts_valid;
  logic [15:0]   drop_count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 tx_clk = ~tx_clk;

  eth_tx_arb_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TAG_WIDTH(TW)) bus ();

  eth_tx_arb #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TAG_WIDTH(TW)) dut (
    .tx_clk          (tx_clk),
    .tx_rst_n        (tx_rst_n),
    .bus             (bus),
    .tx_ptp_ts       (tx_ptp_ts),
    .tx_ptp_ts_tag   (tx_ptp_ts_tag),
    .tx_ptp_ts_valid (tx_ptp_ts_valid),
    .m_ptp_ts        (m_ptp_ts),
    .m_ptp_ts_valid  (m_ptp_ts_valid),
    .drop_count      (drop_count)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge tx_clk);
    #1;
  endtask

  function automatic logic [DW-1:0] beat_data(input int p, input int b);
    return {16'hD0D0, 16'(p), 32'(b)};
  endfunction

  task automatic set_port(input int p, input logic v, input int b, input logic last);
    bus.s_axis_tvalid[p]        = v;
    bus.s_axis_tdata[p*DW +: DW] = beat_data(p, b);
    bus.s_axis_tkeep[p*KW +: KW] = last ? 8'h0F : 8'hFF;
    bus.s_axis_tlast[p]          = last;
  endtask

  task automatic check_beat(input int p, input int b, input logic last, input logic [TW:0] tuser);
    logic [1:0] rdy;
    rdy = bus.tx_axis_tready ? ((p == 1) ? 2'b10 : 2'b01) : 2'b00;
    chk("tvalid", bus.tx_axis_tvalid, 1'b1);
    chk("tdata",  bus.tx_axis_tdata, beat_data(p, b));
    chk("tkeep",  bus.tx_axis_tkeep, last ? 8'h0F : 8'hFF);
    chk("tlast",  bus.tx_axis_tlast, last);
    chk("tuser",  bus.tx_axis_tuser, tuser);
    chk("s_tready", bus.s_axis_tready, rdy);
  endtask

  // Frame with tready held high, starting in an IDLE cycle; ends in the gap cycle
  task automatic send_frame(input int p, input int n, input logic [TW:0] tuser);
    for (int b = 0; b < n; b++) begin
      set_port(p, 1'b1, b, (b == n - 1));
      #1;
      if (b == 0) begin
        chk("idle_before_grant", bus.tx_axis_tvalid, 1'b0);
        tick();
      end
      check_beat(p, b, (b == n - 1), tuser);
      tick();
    end
    set_port(p, 1'b0, 0, 1'b0);
    #1;
    chk("gap_tvalid", bus.tx_axis_tvalid, 1'b0);
    chk("gap_tready", bus.s_axis_tready, 2'b00);
  endtask

  task automatic do_reset();
    tx_rst_n = 1'b0;
    bus.s_axis_tvalid = 2'b00;
    bus.s_axis_tlast  = 2'b00;
    tx_ptp_ts_valid   = 1'b0;
    tick();
    tick();
    tx_rst_n = 1'b1;
  endtask

  initial begin
    int b;
    int cyc;
    bus.s_axis_tdata   = '0;
    bus.s_axis_tkeep   = '0;
    bus.tx_axis_tready = 1'b0;
    tx_ptp_ts          = 96'd0;
    tx_ptp_ts_tag      = 16'h0000;

    // Reset state
    do_reset();
    chk("rst_tvalid", bus.tx_axis_tvalid, 1'b0);
    chk("rst_tready", bus.s_axis_tready, 2'b00);
    chk("rst_drop", drop_count, 16'd0);
    chk("rst_tsv", m_ptp_ts_valid, 2'b00);
    chk("rst_ts", m_ptp_ts, 96'd0);

    // Port 0, 3-beat frame, tag 0x0000
    bus.tx_axis_tready = 1'b1;
    send_frame(0, 3, 17'h00000);

    // Timestamp for an unsent port-0 frame is dropped; a valid one pulses port 0 once
    tx_ptp_ts_valid = 1'b1; tx_ptp_ts_tag = 16'h0005; tx_ptp_ts = 96'h555;
    tick();
    tx_ptp_ts_valid = 1'b0;
    chk("drop_no_pulse", m_ptp_ts_valid, 2'b00);
    chk("drop_count1", drop_count, 16'd1);
    tx_ptp_ts_valid = 1'b1; tx_ptp_ts_tag = 16'h0000; tx_ptp_ts = 96'hABC;
    tick();
    tx_ptp_ts_valid = 1'b0;
    chk("ts0_pulse", m_ptp_ts_valid, 2'b01);
    chk("ts0_value", m_ptp_ts, 96'hABC);
    tick();
    chk("ts0_one_cycle", m_ptp_ts_valid, 2'b00);

    // Port 1 wins (rr_ptr=1) over a waiting port 0; 4 beats with tready toggling 1,0,1,0
    set_port(0, 1'b1, 0, 1'b1);
    set_port(1, 1'b1, 0, 1'b0);
    #1;
    chk("p1_idle", bus.tx_axis_tvalid, 1'b0);
    tick();
    b = 0;
    cyc = 0;
    while (b < 4 && cyc < 20) begin
      bus.tx_axis_tready = (cyc % 2 == 0);
      set_port(1, 1'b1, b, (b == 3));
      #1;
      check_beat(1, b, (b == 3), 17'h10000);
      tick();
      if (bus.tx_axis_tready) b++;
      cyc++;
    end
    chk("p1_beats", 32'(b), 32'd4);
    chk("p1_cycles", 32'(cyc), 32'd7);
    bus.tx_axis_tready = 1'b1;
    set_port(1, 1'b0, 0, 1'b0);
    // Port 0 has waited; its second frame carries seq 1
    send_frame(0, 1, 17'h00002);

    // Port-1 timestamp for its first frame
    tx_ptp_ts_valid = 1'b1; tx_ptp_ts_tag = 16'h8000; tx_ptp_ts = 96'h123;
    tick();
    tx_ptp_ts_valid = 1'b0;
    chk("ts1_pulse", m_ptp_ts_valid, 2'b10);
    chk("ts1_value", m_ptp_ts, 96'h123);
    chk("ts1_drop_hold", drop_count, 16'd1);
    tick();
    chk("ts1_one_cycle", m_ptp_ts_valid, 2'b00);

    // Reset during beat 2 of a port-1 frame aborts it and clears counters
    set_port(1, 1'b1, 0, 1'b0);
    #1;
    tick();
    check_beat(1, 0, 1'b0, 17'h10002);
    tick();
    set_port(1, 1'b1, 1, 1'b0);
    #1;
    check_beat(1, 1, 1'b0, 17'h10002);
    tx_rst_n = 1'b0;
    set_port(1, 1'b0, 0, 1'b0);
    tick();
    chk("abort_tvalid", bus.tx_axis_tvalid, 1'b0);
    chk("abort_tready", bus.s_axis_tready, 2'b00);
    chk("abort_drop", drop_count, 16'd0);
    chk("abort_ts", m_ptp_ts, 96'd0);
    tx_rst_n = 1'b1;
    send_frame(1, 2, 17'h10000);

    // After reset both ports valid with 1-beat frames: 0,1,0,1 with idle gaps
    do_reset();
    set_port(0, 1'b1, 0, 1'b1);
    set_port(1, 1'b1, 0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("alt_idle", bus.tx_axis_tvalid, 1'b0);
      tick();
      check_beat(k % 2, 0, 1'b1, {1'(k % 2), 15'(k / 2), 1'b0});
      tick();
    end
    set_port(0, 1'b0, 0, 1'b0);
    set_port(1, 1'b0, 0, 1'b0);

    // Push port 0 through 0x7FFF frames, then observe tags 0x7FFF and the wrap to 0
    do_reset();
    set_port(0, 1'b1, 0, 1'b1);
    for (int i = 0; i < 2 * 32767; i++) begin
      @(posedge tx_clk);
    end
    #1;
    chk("wrap_idle", bus.tx_axis_tvalid, 1'b0);
    send_frame(0, 1, 17'h0FFFE);
    send_frame(0, 1, 17'h00000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
